// File: rtl/dac_spi_multi_if.sv
// Parallel request/handshake side and serial DAC pins of dac_spi_multi.
// The master modport belongs to the controller, the slave modport to the write engine.
interface dac_spi_multi_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DW    = 12,
    parameter int unsigned FRAME = 16
);
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CTW = FRAME - DW - CW;

    logic                start;
    logic [NCH*DW-1:0]   ch_data;
    logic [NCH-1:0]      ch_mask;
    logic [CTW-1:0]      ctrl;
    logic                busy;
    logic                done;
    logic                sclk;
    logic                dout;
    logic                sync_n;
    logic                ldac_n;

    modport master (
        output start, ch_data, ch_mask, ctrl,
        input  busy, done, sclk, dout, sync_n, ldac_n
    );

    modport slave (
        input  start, ch_data, ch_mask, ctrl,
        output busy, done, sclk, dout, sync_n, ldac_n
    );
endinterface

// File: rtl/dac_spi_multi.sv
// Multi-channel SYNC-framed serial DAC write engine (AD53xx class), registered pin outputs.
// Build option DAC_SPI_LDAC_EN: one shared ldac_n low pulse after the last word; else ldac_n = 0.
module dac_spi_multi #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned DW      = 12,
    parameter int unsigned FRAME   = 16,
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned GAP     = 4,
    parameter int unsigned LDAC_W  = 2
) (
    input  logic           clk,
    input  logic           RESET_N,
    dac_spi_multi_if.slave bus
);
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CTW  = FRAME - DW - CW;
    localparam int unsigned DCW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BM0  = (FRAME > GAP) ? FRAME : GAP;
    localparam int unsigned BMAX = (BM0 > LDAC_W) ? BM0 : LDAC_W;
    localparam int unsigned BCW  = $clog2(BMAX + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StShift = 3'd1;
    localparam logic [2:0] StGap   = 3'd2;
`ifdef DAC_SPI_LDAC_EN
    localparam logic [2:0] StLdac  = 3'd3;
`endif
    localparam logic [2:0] StDone  = 3'd4;

    // Lowest set bit wins, giving ascending channel order.
    function automatic logic [CW-1:0] first_ch(input logic [NCH-1:0] m);
        logic [CW-1:0] idx;
        idx = '0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (m[k]) idx = CW'(k);
        end
        return idx;
    endfunction

    function automatic logic [FRAME-1:0] make_word(input logic [CW-1:0]     idx,
                                                   input logic [CTW-1:0]    c,
                                                   input logic [NCH*DW-1:0] d);
        return {idx, c, d[idx*DW +: DW]};
    endfunction

    logic [2:0]        state_q, state_d;
    logic [DCW-1:0]    div_q, div_d;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [FRAME-1:0]  shreg_q, shreg_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic [NCH*DW-1:0] data_q, data_d;
    logic [CTW-1:0]    ctrl_q, ctrl_d;

    logic sclk_q, sclk_d;
    logic dout_q, dout_d;
    logic sync_n_q, sync_n_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic          period_end;
    logic          active;
    logic [CW-1:0] acc_idx;
    logic [CW-1:0] nxt_idx;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        mask_d     = mask_q;
        data_d     = data_q;
        ctrl_d     = ctrl_q;
        period_end = (div_q == DCW'(CLK_DIV - 1));
        acc_idx    = first_ch(bus.ch_mask);
        nxt_idx    = first_ch(mask_q);

        case (state_q)
            // DONE accepts a new start exactly like IDLE so back-to-back requests lose no cycle.
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    data_d = bus.ch_data;
                    ctrl_d = bus.ctrl;
                    mask_d = bus.ch_mask;
                    div_d  = '0;
                    bit_d  = '0;
                    if (bus.ch_mask != '0) begin
                        mask_d[acc_idx] = 1'b0;
                        shreg_d         = make_word(acc_idx, bus.ctrl, bus.ch_data);
                        state_d         = StShift;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                div_d = period_end ? '0 : div_q + 1'b1;
                if (period_end) begin
                    shreg_d = {shreg_q[FRAME-2:0], 1'b0};
                    if (bit_q == BCW'(FRAME - 1)) begin
                        bit_d   = '0;
                        state_d = StGap;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StGap: begin
                div_d = period_end ? '0 : div_q + 1'b1;
                if (period_end) begin
                    if (bit_q == BCW'(GAP - 1)) begin
                        bit_d = '0;
                        if (mask_q != '0) begin
                            mask_d[nxt_idx] = 1'b0;
                            shreg_d         = make_word(nxt_idx, ctrl_q, data_q);
                            state_d         = StShift;
                        end else begin
`ifdef DAC_SPI_LDAC_EN
                            state_d = StLdac;
`else
                            state_d = StDone;
`endif
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef DAC_SPI_LDAC_EN
            StLdac: begin
                div_d = period_end ? '0 : div_q + 1'b1;
                if (period_end) begin
                    if (bit_q == BCW'(LDAC_W - 1)) begin
                        bit_d   = '0;
                        state_d = StDone;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = StIdle;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Pins are registered from next-state values so they toggle cleanly on the clock edge.
    always_comb begin
        active = (state_d == StShift) || (state_d == StGap);
`ifdef DAC_SPI_LDAC_EN
        active = active || (state_d == StLdac);
`endif
        sclk_d   = !active || (div_d < DCW'(CLK_DIV / 2));
        dout_d   = (state_d == StShift) && shreg_d[FRAME-1];
        sync_n_d = (state_d != StShift);
        busy_d   = active;
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            ctrl_q   <= '0;
            sclk_q   <= 1'b1;
            dout_q   <= 1'b0;
            sync_n_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            sclk_q   <= sclk_d;
            dout_q   <= dout_d;
            sync_n_q <= sync_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef DAC_SPI_LDAC_EN
    logic ldac_n_q;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            ldac_n_q <= 1'b1;
        end else begin
            ldac_n_q <= (state_d != StLdac);
        end
    end

    assign bus.ldac_n = ldac_n_q;
`else
    // Without a common strobe each channel latches on its own sync_n rise.
    assign bus.ldac_n = 1'b0;
`endif

    assign bus.sclk   = sclk_q;
    assign bus.dout   = dout_q;
    assign bus.sync_n = sync_n_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
